// File: rtl/soc_pkg.sv
// Shared types and constants for the IO bus controller and its decoder.
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } io_state_t;

    localparam logic [3:0]  IO_PORT_A = 4'h0;
    localparam logic [3:0]  IO_UART   = 4'h1;
    localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/io_decode.sv
// Combinational IO address decode: region hit, device slot, population and one-hot select.
module io_decode
    import soc_pkg::*;
#(
    parameter int                ADDR_WIDTH = 24,
    parameter int                IO_BIT     = 22,
    parameter int                NUM_DEV    = 16,
    parameter int                SLOT_W     = $clog2(NUM_DEV),
    parameter logic [NUM_DEV-1:0] DEV_MASK  = NUM_DEV'((1 << IO_PORT_A) | (1 << IO_UART))
) (
    input  logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  is_io,
    output logic [SLOT_W-1:0]     slot,
    output logic                  populated,
    output logic [NUM_DEV-1:0]    sel
);

    // Only the region bit and the slot field matter here; the rest is intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^mem_address;

    assign is_io     = mem_address[IO_BIT];
    assign slot      = mem_address[4 +: SLOT_W];
    assign populated = DEV_MASK[slot];
    assign sel       = NUM_DEV'(1) << slot;

endmodule

// File: rtl/io_bus_controller.sv
// Sequences CPU accesses to the IO region: device strobes, busy handshake, timeout and read return.
module io_bus_controller
    import soc_pkg::*;
#(
    parameter int                 ADDR_WIDTH = 24,
    parameter int                 IO_BIT     = 22,
    parameter int                 NUM_DEV    = 16,
    parameter logic [NUM_DEV-1:0] DEV_MASK   = NUM_DEV'((1 << IO_PORT_A) | (1 << IO_UART)),
    parameter int                 TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   mem_address,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wmask,
    input  logic                    mem_rstrb,
    output logic [31:0]             mem_rdata,
    output logic                    mem_rbusy,
    output logic                    mem_wbusy,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic [3:0]              dev_addr,
    output logic [31:0]             dev_wdata,
    output logic [3:0]              dev_wmask,
    output logic                    dev_rd,
    output logic                    dev_wr,
    input  logic [NUM_DEV*32-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ready,
    output logic                    bus_error
);

    localparam int SLOT_W = $clog2(NUM_DEV);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic               is_io;
    logic               populated;
    logic [SLOT_W-1:0]  slot;
    logic [NUM_DEV-1:0] sel;

    io_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IO_BIT     (IO_BIT),
        .NUM_DEV    (NUM_DEV),
        .SLOT_W     (SLOT_W),
        .DEV_MASK   (DEV_MASK)
    ) u_decode (
        .mem_address (mem_address),
        .is_io       (is_io),
        .slot        (slot),
        .populated   (populated),
        .sel         (sel)
    );

    io_state_t          state_q, state_d;
    logic [NUM_DEV-1:0] sel_q, sel_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               wr_q, wr_d;
    logic [3:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wmask_q, wmask_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic        wr_req;
    logic        req;
    logic        ready;
    logic [31:0] dev_word;

    // A write mask wins over a simultaneous read strobe. Requests are masked during reset
    // so busy never flickers while the block is being cleared.
    assign wr_req   = |mem_wmask;
    assign req      = ~reset & is_io & (mem_rstrb | wr_req);
    assign ready    = |(dev_ready & sel_q);
    assign dev_word = dev_rdata[{slot_q, 5'd0} +: 32];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        slot_d  = slot_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr_req;
                    addr_d  = mem_address[3:0];
                    wdata_d = mem_wdata;
                    wmask_d = mem_wmask;
                    if (populated) begin
                        state_d = ACCESS;
                        sel_d   = sel;
                        slot_d  = slot;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (ready) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = dev_word;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = DEAD_DATA;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            slot_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Busy rises combinationally in the request cycle and falls as DONE is entered.
    assign mem_rbusy = ((state_q == IDLE) & req & ~wr_req) | ((state_q == ACCESS) & ~wr_q);
    assign mem_wbusy = ((state_q == IDLE) & req &  wr_req) | ((state_q == ACCESS) &  wr_q);

    assign dev_sel   = (state_q == ACCESS) ? sel_q : '0;
    assign dev_rd    = (state_q == ACCESS) & ~wr_q;
    assign dev_wr    = (state_q == ACCESS) &  wr_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_wmask = wmask_q;
    assign mem_rdata = rdata_q;
    assign bus_error = err_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller: read/write handshakes, unpopulated slot, timeout, reset abort.
module tb_io_bus_controller;

    logic          clk;
    logic          reset;
    logic [23:0]   mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rstrb;
    logic [31:0]   mem_rdata;
    logic          mem_rbusy;
    logic          mem_wbusy;
    logic [15:0]   dev_sel;
    logic [3:0]    dev_addr;
    logic [31:0]   dev_wdata;
    logic [3:0]    dev_wmask;
    logic          dev_rd;
    logic          dev_wr;
    logic [511:0]  dev_rdata;
    logic [15:0]   dev_ready;
    logic          bus_error;

    int n_chk  = 0;
    int n_fail = 0;

    io_bus_controller dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rstrb   (mem_rstrb),
        .mem_rdata   (mem_rdata),
        .mem_rbusy   (mem_rbusy),
        .mem_wbusy   (mem_wbusy),
        .dev_sel     (dev_sel),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_wmask   (dev_wmask),
        .dev_rd      (dev_rd),
        .dev_wr      (dev_wr),
        .dev_rdata   (dev_rdata),
        .dev_ready   (dev_ready),
        .bus_error   (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic rd_ok;
        reset       = 1'b1;
        mem_address = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        mem_rstrb   = 1'b0;
        dev_rdata   = '0;
        dev_ready   = '0;
        step(); step();
        mid();
        check("rst_rbusy", mem_rbusy, 0);
        check("rst_wbusy", mem_wbusy, 0);
        check("rst_sel",   dev_sel,   0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_err",   bus_error, 0);
        check("rst_strb",  {dev_rd, dev_wr}, 0);
        step();
        reset = 1'b0;

        // 1: UART read, zero-wait
        step();
        mem_address = 24'h400010; mem_rstrb = 1'b1;
        dev_rdata[63:32] = 32'h41; dev_ready = 16'h0002;
        mid();
        check("t1_c0_rbusy", mem_rbusy, 1);
        check("t1_c0_wbusy", mem_wbusy, 0);
        step(); mem_rstrb = 1'b0;
        mid();
        check("t1_c1_sel",   dev_sel,   16'h0002);
        check("t1_c1_rd",    dev_rd,    1);
        check("t1_c1_rbusy", mem_rbusy, 1);
        step();
        mid();
        check("t1_c2_rbusy", mem_rbusy, 0);
        check("t1_c2_rdata", mem_rdata, 32'h41);
        check("t1_c2_sel",   dev_sel,   0);
        step(); mem_address = '0; dev_ready = '0;

        // 2: port A write, ready on the 4th access cycle
        mem_address = 24'h400000; mem_wmask = 4'h1; mem_wdata = 32'hA5;
        mid();
        check("t2_c0_wbusy", mem_wbusy, 1);
        for (int k = 0; k < 4; k++) begin
            step(); mem_wmask = '0;
            dev_ready = (k == 3) ? 16'h0001 : 16'h0000;
            mid();
            check("t2_wr",    dev_wr,    1);
            check("t2_wdata", dev_wdata, 32'hA5);
            check("t2_sel",   dev_sel,   16'h0001);
            check("t2_wbusy", mem_wbusy, 1);
        end
        step(); dev_ready = '0;
        mid();
        check("t2_done_wr",    dev_wr,    0);
        check("t2_done_wbusy", mem_wbusy, 0);
        check("t2_done_wmask", dev_wmask, 4'h1);
        check("t2_err",        bus_error, 0);
        step(); mem_address = '0;

        // 6a: RAM read is transparent
        mem_address = 24'h000100; mem_rstrb = 1'b1;
        mid();
        check("t6_ram_rbusy", mem_rbusy, 0);
        check("t6_ram_wbusy", mem_wbusy, 0);
        check("t6_ram_sel",   dev_sel,   0);
        step(); mem_rstrb = 1'b0;
        mid();
        check("t6_ram_rd", dev_rd, 0);
        // 6b: rstrb + wmask to IO is a write
        step();
        mem_address = 24'h400010; mem_rstrb = 1'b1; mem_wmask = 4'hF; mem_wdata = 32'h12345678;
        mid();
        check("t6_c0_wbusy", mem_wbusy, 1);
        check("t6_c0_rbusy", mem_rbusy, 0);
        step(); mem_rstrb = 1'b0; mem_wmask = '0; dev_ready = 16'h0002;
        mid();
        check("t6_c1_wr",    dev_wr,    1);
        check("t6_c1_rd",    dev_rd,    0);
        check("t6_c1_wdata", dev_wdata, 32'h12345678);
        step(); dev_ready = '0;
        mid();
        check("t6_c2_wbusy", mem_wbusy, 0);
        check("t6_c2_rd",    dev_rd,    0);
        step(); mem_address = '0;

        // 3: unpopulated slot 2
        mem_address = 24'h400020; mem_rstrb = 1'b1;
        mid();
        check("t3_c0_rbusy", mem_rbusy, 1);
        check("t3_c0_rd",    dev_rd,    0);
        step(); mem_rstrb = 1'b0;
        mid();
        check("t3_c1_rbusy", mem_rbusy, 0);
        check("t3_c1_rd",    dev_rd,    0);
        check("t3_c1_sel",   dev_sel,   0);
        check("t3_c1_rdata", mem_rdata, 0);
        check("t3_c1_err",   bus_error, 1);
        step(); mem_address = '0;

        // 4: UART timeout; other slots acking must be ignored
        mem_address = 24'h400010; mem_rstrb = 1'b1; dev_ready = 16'hFFFD;
        mid();
        step(); mem_rstrb = 1'b0;
        n = 0; rd_ok = 1'b1;
        while (mem_rbusy && n < 400) begin
            if (!dev_rd) rd_ok = 1'b0;
            n++;
            step();
        end
        check("t4_access_cycles", n, 256);
        check("t4_rd_level",      rd_ok, 1);
        check("t4_rdata",         mem_rdata, 32'hDEADBEEF);
        check("t4_err",           bus_error, 1);
        check("t4_sel",           dev_sel, 0);
        step(); dev_ready = '0; mem_address = '0;
        mid();
        check("t4_idle_rbusy", mem_rbusy, 0);

        // 5: reset during ACCESS cycle 2
        step();
        mem_address = 24'h400010; mem_rstrb = 1'b1;
        step(); mem_rstrb = 1'b0;
        step(); reset = 1'b1;
        mid();
        check("t5_pre_rd", dev_rd, 1);
        step(); reset = 1'b0;
        mid();
        check("t5_rbusy", mem_rbusy, 0);
        check("t5_rd",    dev_rd,    0);
        check("t5_sel",   dev_sel,   0);
        check("t5_err",   bus_error, 0);
        check("t5_rdata", mem_rdata, 0);
        step();
        mid();
        check("t5_after_rbusy", mem_rbusy, 0);
        check("t5_after_rdata", mem_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
